// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Holds size defaults, the zero-register index and the highest-port select helper.
package regfile_pkg;

  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 5;
  localparam int NUM_RD_D = 2;
  localparam int NUM_WR_D = 2;

  localparam int REG_ZERO = 0;

  localparam int MAX_WR = 16;
  localparam int PORT_W = 4;

  // Index of the highest set bit of a port-match vector (0 when none).
  function automatic logic [PORT_W-1:0] hi_port(
    input logic [MAX_WR-1:0] m
  );
    logic [PORT_W-1:0] s;
    s = '0;
    for (int i = 0; i < MAX_WR; i++)
      if (m[i]) s = PORT_W'(i);
    return s;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: per-register pending-producer bits plus registered popcount.
// Ports: clk, rst, wr_en/wr_addr (clear), iss_en/iss_addr (set), busy, busy_cnt.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int NUM_WR   = NUM_WR_D,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [2**ADDR_W-1:0]     busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_n;
  logic [ADDR_W:0]  cnt_n;

  // Clears first, then the issue set, so a new producer wins.
  always_comb begin
    busy_n = busy;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_en[p])
        busy_n[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
    if (iss_en)
      busy_n[iss_addr] = 1'b1;
    if (ZERO_REG != 0)
      busy_n[REG_ZERO] = 1'b0;
  end

  always_comb begin
    cnt_n = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_n = cnt_n + {{ADDR_W{1'b0}}, busy_n[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_n;
      busy_cnt <= cnt_n;
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// Multi-port register file: async reads, sync writes, busy scoreboard.
// Optional write-to-read bypass when REGFILE_BYPASS_EN is defined.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int NUM_RD   = NUM_RD_D,
  parameter int NUM_WR   = NUM_WR_D,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Later ports are assigned last, so the highest port wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en[p] &&
            !(ZERO_REG != 0 &&
              wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)))
          regs[wr_addr[p*ADDR_W +: ADDR_W]] <=
            wr_data[p*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              z;
    logic [DATA_W-1:0] v;
    logic              b;
`ifdef REGFILE_BYPASS_EN
    logic [NUM_WR-1:0] m;
    logic [PORT_W-1:0] sel;
`endif
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      ra = rd_addr[r*ADDR_W +: ADDR_W];
      z  = (ZERO_REG != 0) && (ra == ADDR_W'(REG_ZERO));
      v  = z ? '0 : regs[ra];
      b  = !z && busy[ra];
`ifdef REGFILE_BYPASS_EN
      // Forward same-cycle write data; busy only if re-issued now.
      m = '0;
      for (int p = 0; p < NUM_WR; p++)
        m[p] = wr_en[p] && !rst && !z &&
               (wr_addr[p*ADDR_W +: ADDR_W] == ra);
      sel = hi_port(MAX_WR'(m));
      for (int p = 0; p < NUM_WR; p++)
        if (m[p] && sel == PORT_W'(p))
          v = wr_data[p*DATA_W +: DATA_W];
      if (|m)
        b = iss_en && (iss_addr == ra);
`endif
      rd_data[r*DATA_W +: DATA_W] = v;
      rd_busy[r] = b;
    end
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench for multiport_regfile (default parameters).
// Directed scenarios with literal expectations plus random traffic vs a model.
module tb_multiport_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  multiport_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] wa(int p);
    return wr_addr[p*5 +: 5];
  endfunction

  function automatic logic [31:0] wd(int p);
    return wr_data[p*32 +: 32];
  endfunction

  // Model: architectural state changes only at clock edges.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wa(p) != 0) m_regs[wa(p)] = wd(p);
      for (int p = 0; p < 2; p++)
        if (wr_en[p]) m_busy[wa(p)] = 1'b0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(logic [4:0] a);
    logic [31:0] v;
    v = (a == 0) ? 32'h0 : m_regs[a];
`ifdef REGFILE_BYPASS_EN
    if (!rst && a != 0)
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wa(p) == a) v = wd(p);
`endif
    return v;
  endfunction

  function automatic logic exp_busy(logic [4:0] a);
    logic b;
    b = (a != 0) && m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (!rst && a != 0 &&
        ((wr_en[0] && wa(0) == a) || (wr_en[1] && wa(1) == a)))
      b = iss_en && iss_addr == a;
`endif
    return b;
  endfunction

  function automatic logic [31:0] exp_cnt();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return 32'(n);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("rd_data%0d", r), rd_data[r*32 +: 32],
            exp_data(rd_addr[r*5 +: 5]));
        chk($sformatf("rd_busy%0d", r), 32'(rd_busy[r]),
            32'(exp_busy(rd_addr[r*5 +: 5])));
      end
      chk("busy_cnt", 32'(busy_cnt), exp_cnt());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(int p, logic [4:0] a, logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  initial begin
    repeat (2) tick();
    probe();
    chk("rst_rd0", rd_data[31:0], 32'h0);
    chk("rst_busy", 32'(rd_busy), 32'h0);
    chk("rst_cnt", 32'(busy_cnt), 32'h0);
    tick();
    rst = 1'b0;
    chk_on = 1'b1;

    // Same-edge write on both ports to r3: port 1 wins.
    wr(0, 5'd3, 32'h11);
    wr(1, 5'd3, 32'h22);
    tick();
    idle();
    rd_addr[4:0] = 5'd3;
    probe();
    chk("t2_r3", rd_data[31:0], 32'h22);

    // r0 ignores writes and issues.
    wr(0, 5'd0, 32'hFFFFFFFF);
    iss_en = 1'b1;
    iss_addr = 5'd0;
    tick();
    idle();
    rd_addr[4:0] = 5'd0;
    probe();
    chk("t3_r0", rd_data[31:0], 32'h0);
    chk("t3_busy", 32'(rd_busy[0]), 32'h0);
    chk("t3_cnt", 32'(busy_cnt), 32'h0);

    // Issue then writeback on r7.
    iss_en = 1'b1;
    iss_addr = 5'd7;
    tick();
    idle();
    rd_addr[4:0] = 5'd7;
    probe();
    chk("t4_busy", 32'(rd_busy[0]), 32'h1);
    chk("t4_cnt", 32'(busy_cnt), 32'h1);
    wr(0, 5'd7, 32'h55);
    tick();
    idle();
    probe();
    chk("t4_busy2", 32'(rd_busy[0]), 32'h0);
    chk("t4_cnt2", 32'(busy_cnt), 32'h0);
    chk("t4_r7", rd_data[31:0], 32'h55);

    // Issue and writeback of r9 on the same edge.
    iss_en = 1'b1;
    iss_addr = 5'd9;
    wr(1, 5'd9, 32'hAB);
    tick();
    idle();
    rd_addr[4:0] = 5'd9;
    probe();
    chk("t5_busy", 32'(rd_busy[0]), 32'h1);
    chk("t5_r9", rd_data[31:0], 32'hAB);
    chk("t5_cnt", 32'(busy_cnt), 32'h1);
    wr(0, 5'd9, 32'hAB);
    tick();
    idle();

    // Read r4 during its write.
    rd_addr[9:5] = 5'd4;
    wr(0, 5'd4, 32'h1234);
    probe();
`ifdef REGFILE_BYPASS_EN
    chk("t6_byp", rd_data[63:32], 32'h1234);
`else
    chk("t6_old", rd_data[63:32], 32'h0);
`endif
    tick();
    idle();
    probe();
    chk("t6_after", rd_data[63:32], 32'h1234);

    // Random traffic; half the addresses in a narrow range for collisions.
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        wr_en[p] = ($urandom_range(0, 2) != 0);
        wr_addr[p*5 +: 5] = $urandom_range(0, 1) ?
          5'($urandom_range(0, 7)) : 5'($urandom);
        wr_data[p*32 +: 32] = $urandom;
      end
      for (int r = 0; r < 2; r++)
        rd_addr[r*5 +: 5] = $urandom_range(0, 1) ?
          5'($urandom_range(0, 7)) : 5'($urandom);
      iss_en = ($urandom_range(0, 1) != 0);
      iss_addr = $urandom_range(0, 1) ?
        5'($urandom_range(0, 7)) : 5'($urandom);
    end

    // Reset mid-run after writing r5.
    tick();
    idle();
    wr(0, 5'd5, 32'hDEADBEEF);
    iss_en = 1'b1;
    iss_addr = 5'd6;
    tick();
    rd_addr[4:0] = 5'd5;
    rd_addr[9:5] = 5'd6;
    wr(1, 5'd5, 32'h77);
    rst = 1'b1;
    probe();
    chk("t1_r5", rd_data[31:0], 32'h0);
    chk("t1_cnt", 32'(busy_cnt), 32'h0);
    chk("t1_busy", 32'(rd_busy), 32'h0);
    tick();
    idle();
    rst = 1'b0;
    probe();
    chk("t1_r5_post", rd_data[31:0], 32'h0);
    tick();

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
